// File: rtl/leaf_stage_pkg.sv
// leaf_stage_pkg: shared constants, types and helpers for the leaf FIFO stage.
// Holds default sizing, drop-counter width and the saturating increment.
package leaf_stage_pkg;

  localparam int LEAF_DATA_W_DEF = 8;
  localparam int LEAF_DEPTH_DEF  = 4;
  localparam int DROP_CNT_W      = 16;

  typedef logic [LEAF_DATA_W_DEF-1:0] leaf_word_t;
  typedef logic [DROP_CNT_W-1:0]      drop_cnt_t;

  function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/leaf_stage_fifo_ctrl.sv
// leaf_stage_fifo_ctrl: pointer, occupancy and drop-count bookkeeping.
// Ports: clk, rst, in_valid, out_ready -> push, pop, wr_ptr, rd_ptr,
//        count, full, empty, drop_cnt.
module leaf_stage_fifo_ctrl
  import leaf_stage_pkg::*;
#(
  parameter  int DEPTH = LEAF_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          push,
  output logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output drop_cnt_t     drop_cnt
);

  // full/empty come from the registered count only, so in_ready never
  // depends combinationally on out_ready.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = in_valid & ~full;
  assign pop   = out_ready & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // DEPTH is a power of two, so the natural roll-over is the wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (in_valid && full) begin
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: rtl/leaf_stage_fifo.sv
// leaf_stage_fifo: valid/ready FIFO stage, registered storage, comb read.
// Ports: clk, rst, in_valid/in_data/in_ready, out_valid/out_data/out_ready,
//        count, drop_cnt; parity_err when LEAF_STAGE_FIFO_PARITY_EN defined.
module leaf_stage_fifo
  import leaf_stage_pkg::*;
#(
  parameter  int DATA_W = $bits(leaf_word_t),
  parameter  int DEPTH  = LEAF_DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CW-1:0]     count,
  output drop_cnt_t         drop_cnt
`ifdef LEAF_STAGE_FIFO_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [DATA_W-1:0] mem [DEPTH];

  leaf_stage_fifo_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .push     (push),
    .pop      (pop),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .drop_cnt (drop_cnt)
  );

  assign in_ready  = ~full;
  assign out_valid = ~empty;

  // A push in the reset cycle must not land in storage.
  assign wr_en = push & ~rst;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  assign out_data = mem[rd_ptr];

`ifdef LEAF_STAGE_FIFO_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_ptr] <= ^in_data;
  end

  // Gated by out_valid, which is low straight out of reset.
  assign parity_err = out_valid & ((^out_data) != par_mem[rd_ptr]);
`endif

  logic unused_pop;
  assign unused_pop = pop;

endmodule

// File: tb/tb_leaf_stage_fifo.sv
// tb_leaf_stage_fifo: directed bench with a queue reference model.
// Checks every cycle against the model plus literal expectations.
module tb_leaf_stage_fifo;
  import leaf_stage_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  leaf_word_t in_data = '0;
  logic       in_ready;
  logic       out_valid;
  leaf_word_t out_data;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  drop_cnt_t  drop_cnt;
`ifdef LEAF_STAGE_FIFO_PARITY_EN
  logic       parity_err;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  leaf_word_t mq[$];
  leaf_word_t rx[$];
  int         m_drop = 0;

  leaf_stage_fifo #(
    .DATA_W(8),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .drop_cnt (drop_cnt)
`ifdef LEAF_STAGE_FIFO_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue updated with the pre-edge inputs.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_drop = 0;
    end else begin
      automatic bit was_full = (mq.size() >= DEPTH);
      automatic bit do_pop   = (mq.size() > 0) && out_ready;
      automatic bit do_push  = in_valid && !was_full;
      if (in_valid && was_full && m_drop < 16'hFFFF) m_drop++;
      if (do_pop) rx.push_back(mq.pop_front());
      if (do_push) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("cyc_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("cyc_count", 32'(count), 32'(mq.size()));
      chk("cyc_drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (mq.size() != 0) chk("cyc_out_data", 32'(out_data), 32'(mq[0]));
    end
  end

  task automatic step(input logic v, input leaf_word_t d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    leaf_word_t fill [4];
    int idx;
    int cyc;
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    rst = 1'b1;
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_init_count", 32'(count), 0);
    chk("rst_init_in_ready", 32'(in_ready), 1);

    // Reset mid-fill of 3 words; push/pop during reset are ignored.
    step(1, 8'hC1, 0);
    step(1, 8'hC2, 0);
    step(1, 8'hC3, 0);
    chk("prefill_count", 32'(count), 3);
    rst = 1'b1;
    step(1, 8'hC4, 1);
    step(1, 8'hC5, 1);
    rst = 1'b0;
    step(0, 8'h00, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);

    // Fill to full.
    for (int i = 0; i < 4; i++) step(1, fill[i], 0);
    chk("fill_count", 32'(count), 4);
    chk("fill_in_ready", 32'(in_ready), 0);

    // Refused pushes while full.
    for (int i = 0; i < 3; i++) step(1, 8'hEE, 0);
    chk("drop_cnt", 32'(drop_cnt), 3);
    chk("drop_count", 32'(count), 4);
    chk("drop_head", 32'(out_data), 32'h11);

    // Drain in order.
    rx.delete();
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", 32'(out_data), 32'(fill[i]));
      step(0, 8'h00, 1);
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_rx_n", 32'(rx.size()), 4);

    // Simultaneous push and pop at count=2.
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    chk("sim_pre_count", 32'(count), 2);
    step(1, 8'hA5, 1);
    chk("sim_count", 32'(count), 2);
    chk("sim_head0", 32'(out_data), 32'h02);
    step(0, 8'h00, 1);
    chk("sim_head1", 32'(out_data), 32'hA5);
    step(0, 8'h00, 1);
    chk("sim_empty", 32'(out_valid), 0);

    // Stream 10 words with out_ready toggling; wraps pointers.
    rx.delete();
    idx = 0;
    cyc = 0;
    while (rx.size() < 10 && cyc < 200) begin
      automatic bit v = (idx < 10);
      automatic bit acc = v && (mq.size() < DEPTH);
      step(v, leaf_word_t'(idx), cyc[0]);
      if (acc) idx++;
      cyc++;
    end
    if (cyc >= 200) begin
      errors++;
      checks++;
      $display("FAIL wrap_timeout: got %0d words expected 10", rx.size());
    end
    chk("wrap_rx_n", 32'(rx.size()), 10);
    for (int i = 0; i < 10 && i < rx.size(); i++)
      chk("wrap_order", 32'(rx[i]), 32'(i));
    step(0, 8'h00, 0);
    chk("wrap_count", 32'(count), 0);

`ifdef LEAF_STAGE_FIFO_PARITY_EN
    step(1, 8'h3C, 0);
    step(1, 8'h5A, 0);
    chk("par_clean", 32'(parity_err), 0);
    dut.mem[dut.rd_ptr][0] = ~dut.mem[dut.rd_ptr][0];
    mq[0] = mq[0] ^ 8'h01;
    #1;
    chk("par_err_hi", 32'(parity_err), 1);
    step(0, 8'h00, 1);
    chk("par_err_lo", 32'(parity_err), 0);
    step(0, 8'h00, 1);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
